// File: rtl/fwd_hazard_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard unit.
// Optional build macro: FWD_HAZARD_STATS_EN (enables the stall/forward counters).
package fwd_hazard_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned CNT_W    = 32;

  // Operand mux select encoding
  localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b10;
  localparam logic [SEL_W-1:0] SEL_LINK  = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Register-usage record carried down the shadow pipeline
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic              reg_write;
    logic              mem_read;
    logic              is_link;
  } stage_info_t;

  // Priority select for one source register: MEM beats WB, $0 never forwards.
  // A load sitting in MEM with a match cannot occur after a stall; if it does, fall back to RF.
  function automatic logic [SEL_W-1:0] fwd_select(
    input logic [REG_AW-1:0] src,
    input logic              mem_wr,
    input logic [REG_AW-1:0] mem_dest,
    input logic              mem_load,
    input logic              mem_link,
    input logic              wb_wr,
    input logic [REG_AW-1:0] wb_dest
  );
    logic src_nz;
    logic mem_hit;
    logic wb_hit;
    logic [SEL_W-1:0] sel;
    src_nz  = (src != REG_AW'(ZERO_REG));
    mem_hit = mem_wr && (mem_dest == src) && src_nz;
    wb_hit  = wb_wr && (wb_dest == src) && src_nz;
    sel     = SEL_RF;
    if (mem_hit) begin
      if (mem_load) begin
        sel = SEL_RF;
      end else if (mem_link) begin
        sel = SEL_LINK;
      end else begin
        sel = SEL_EXMEM;
      end
    end else if (wb_hit) begin
      sel = SEL_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage of register-usage info; kill clears only the valid bit.
module hazard_stage_reg
  import fwd_hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        kill,
  input  stage_info_t d,
  output stage_info_t q
);

  stage_info_t stage_d;
  stage_info_t stage_q;

  // Next stage contents: pass through, turning a killed slot into a bubble
  always_comb begin
    stage_d = d;
    if (kill) begin
      stage_d.valid = 1'b0;
    end
  end

  // Stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard control for the 5-stage MIPS datapath.
// Drives the EX operand mux selects from a private EX/MEM/WB shadow pipeline and
// stalls IF/ID for one cycle on a load-use dependency.
// Optional build macro: FWD_HAZARD_STATS_EN adds stall and forwarding counters;
// without it both counter ports are constant zero.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_is_link,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              ex_bubble,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  fwd_count
);

  stage_info_t id_info;
  stage_info_t ex_info;
  stage_info_t mem_info;
  stage_info_t wb_info;

  state_e state_q;
  state_e state_d;

  logic hazard_c;
  logic stall_c;
  logic ex_kill_c;

  // Pack the ID-stage fields into a stage record
  always_comb begin
    id_info           = '0;
    id_info.valid     = id_valid;
    id_info.rs        = id_rs;
    id_info.rt        = id_rt;
    id_info.dest      = id_dest;
    id_info.reg_write = id_reg_write;
    id_info.mem_read  = id_mem_read;
    id_info.is_link   = id_is_link;
  end

  // Load in EX whose result is needed by the instruction in ID
  always_comb begin
    hazard_c = 1'b0;
    if ((state_q == ST_RUN) && ex_info.valid && ex_info.mem_read &&
        (ex_info.dest != REG_AW'(ZERO_REG)) && id_valid &&
        ((ex_info.dest == id_rs) || (ex_info.dest == id_rt))) begin
      hazard_c = 1'b1;
    end
  end

  // A flush overrides the hazard: no stall, the ID slot just becomes a bubble
  assign stall_c   = hazard_c && !flush;
  assign ex_kill_c = hazard_c || flush;

  // Shadow pipeline: ID -> EX -> MEM -> WB
  hazard_stage_reg u_ex_stage (
    .clk  (clk),
    .rst  (rst),
    .kill (ex_kill_c),
    .d    (id_info),
    .q    (ex_info)
  );

  hazard_stage_reg u_mem_stage (
    .clk  (clk),
    .rst  (rst),
    .kill (1'b0),
    .d    (ex_info),
    .q    (mem_info)
  );

  hazard_stage_reg u_wb_stage (
    .clk  (clk),
    .rst  (rst),
    .kill (1'b0),
    .d    (mem_info),
    .q    (wb_info)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and stall controls; STALL lasts exactly one cycle since the load has moved on
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    ex_bubble   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (stall_c) begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (!rst) begin
      if (stall_c) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ex_bubble   = 1'b1;
      end else begin
        ex_bubble   = flush;
      end
    end
  end

  // Operand selects for the instruction currently in EX
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (ex_info.valid) begin
      fwd_a_sel = fwd_select(ex_info.rs,
                             mem_info.valid && mem_info.reg_write, mem_info.dest,
                             mem_info.mem_read, mem_info.is_link,
                             wb_info.valid && wb_info.reg_write, wb_info.dest);
      fwd_b_sel = fwd_select(ex_info.rt,
                             mem_info.valid && mem_info.reg_write, mem_info.dest,
                             mem_info.mem_read, mem_info.is_link,
                             wb_info.valid && wb_info.reg_write, wb_info.dest);
    end
  end

  // WB only needs its write port; the remaining fields ride along for symmetry
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_info.rs, wb_info.rt, wb_info.mem_read, wb_info.is_link};

`ifdef FWD_HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;
  logic [CNT_W-1:0] fwd_count_q;
  logic [CNT_W-1:0] fwd_count_d;

  // Count stall entries and cycles with any forwarded operand; both wrap naturally
  always_comb begin
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if ((state_q == ST_RUN) && (state_d == ST_STALL)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if ((fwd_a_sel != SEL_RF) || (fwd_b_sel != SEL_RF)) begin
      fwd_count_d = fwd_count_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;
`else
  assign stall_count = '0;
  assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: stimulus pushes hand-computed expectations
// into a queue, a negedge monitor pops one per cycle and compares.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_dest;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_is_link;
  logic        flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        pc_write;
  logic        if_id_write;
  logic        ex_bubble;
  logic [31:0] stall_count;
  logic [31:0] fwd_count;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_is_link   (id_is_link),
    .flush        (flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .ex_bubble    (ex_bubble),
    .stall_count  (stall_count),
    .fwd_count    (fwd_count)
  );

  typedef struct {
    string       name;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        pcw;
    logic        ifw;
    logic        bub;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];
  int   compared;
  int   mismatched;
  int   exp_stall;
  int   exp_fwd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "fwd_a_sel",   32'(fwd_a_sel),   32'(e.a));
      chk(e.name, "fwd_b_sel",   32'(fwd_b_sel),   32'(e.b));
      chk(e.name, "pc_write",    32'(pc_write),    32'(e.pcw));
      chk(e.name, "if_id_write", 32'(if_id_write), 32'(e.ifw));
      chk(e.name, "ex_bubble",   32'(ex_bubble),   32'(e.bub));
      chk(e.name, "stall_count", stall_count,      e.sc);
      chk(e.name, "fwd_count",   fwd_count,        e.fc);
    end
  end

  task automatic push(input string nm, input logic [1:0] ea, input logic [1:0] eb,
                      input logic stall, input logic bub);
    exp_t e;
    e.name = nm;
    e.a    = ea;
    e.b    = eb;
    e.pcw  = !stall;
    e.ifw  = !stall;
    e.bub  = bub;
    e.sc   = 32'(exp_stall);
    e.fc   = 32'(exp_fwd);
    sb.push_back(e);
`ifdef FWD_HAZARD_STATS_EN
    if (ea != 2'b00 || eb != 2'b00) exp_fwd++;
    if (stall) exp_stall++;
`endif
  endtask

  // Drive one ID slot for one cycle and record what the DUT must show that cycle
  task automatic step(input string nm, input bit v, input int rs, input int rt, input int dst,
                      input bit rw, input bit mr, input bit lk, input bit fl,
                      input logic [1:0] ea, input logic [1:0] eb, input bit stall, input bit bub);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    id_valid     = v;
    id_rs        = 5'(rs);
    id_rt        = 5'(rt);
    id_dest      = 5'(dst);
    id_reg_write = rw;
    id_mem_read  = mr;
    id_is_link   = lk;
    flush        = fl;
    push(nm, ea, eb, stall, bub);
  endtask

  task automatic nop(input string nm, input logic [1:0] ea, input logic [1:0] eb);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb, 0, 0);
  endtask

  // Assert reset mid-cycle, leaving the ID inputs as they are
  task automatic reset_step(input string nm);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    exp_stall = 0;
    exp_fwd   = 0;
    push(nm, 2'b00, 2'b00, 0, 0);
  endtask

  initial begin
    compared = 0; mismatched = 0; exp_stall = 0; exp_fwd = 0;
    rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_dest = 0;
    id_reg_write = 0; id_mem_read = 0; id_is_link = 0; flush = 0;

    reset_step("reset");
    nop("idle", 2'b00, 2'b00);

    // add $3 ; sub $5,$3,$4
    step("alu_add",  1, 1, 2, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("alu_sub",  1, 3, 4, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    nop("alu_dep", 2'b01, 2'b00);
    nop("alu_d1",  2'b00, 2'b00);
    nop("alu_d2",  2'b00, 2'b00);

    // $3 written twice back to back, then read on both operands
    step("dm_i1", 1, 1, 2, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("dm_i2", 1, 6, 7, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("dm_i3", 1, 3, 3, 10, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    nop("double_match", 2'b01, 2'b01);
    nop("dm_d1", 2'b00, 2'b00);
    nop("dm_d2", 2'b00, 2'b00);

    // lw $8 ; add $9,$8,$8
    step("lu_lw",    1, 1, 8, 8, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    step("lu_stall", 1, 8, 8, 9, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    step("lu_held",  1, 8, 8, 9, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    nop("lu_fwd", 2'b10, 2'b10);
    nop("lu_d1",  2'b00, 2'b00);
    nop("lu_d2",  2'b00, 2'b00);

    // lw $0 ; use $0
    step("z_lw",       1, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    step("z_no_stall", 1, 0, 0, 4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    nop("z_sel", 2'b00, 2'b00);
    nop("z_d1",  2'b00, 2'b00);
    nop("z_d2",  2'b00, 2'b00);

    // jal -> $31 ; read $31
    step("lk_jal", 1, 0, 0, 31, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0);
    step("lk_use", 1, 31, 5, 6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    nop("link_fwd", 2'b11, 2'b00);
    nop("lk_d1", 2'b00, 2'b00);
    nop("lk_d2", 2'b00, 2'b00);

    // load-use hazard coinciding with a flush
    step("hf_lw",    1, 1, 7, 7, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    step("haz_flush", 1, 7, 2, 8, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    nop("hf_next", 2'b00, 2'b00);
    nop("hf_d1",   2'b00, 2'b00);
    nop("hf_d2",   2'b00, 2'b00);

    // flush alone kills a dependent instruction before it can forward
    step("fk_add",     1, 1, 2, 12, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step("flush_only", 1, 12, 12, 13, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    nop("flush_kill", 2'b00, 2'b00);
    nop("fk_d1", 2'b00, 2'b00);
    nop("fk_d2", 2'b00, 2'b00);

    // reset asserted in the STALL cycle
    step("rs_lw",    1, 1, 13, 13, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    step("rs_stall", 1, 13, 0, 14, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    reset_step("reset_mid_stall");
    step("rs_after", 1, 13, 0, 14, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    nop("rs_d1", 2'b00, 2'b00);
    nop("rs_d2", 2'b00, 2'b00);

    // load-use through operand B only
    step("rt_lw",    1, 2, 20, 20, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    step("rt_stall", 1, 1, 20, 21, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    step("rt_held",  1, 1, 20, 21, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    nop("rt_fwd", 2'b00, 2'b10);
    nop("rt_d1",  2'b00, 2'b00);
    nop("rt_d2",  2'b00, 2'b00);

    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
